vga_timing_gen: RTL and testbench

- Generates 640x480@60 Hz VGA raster timing from the 100 MHz system clock.
- Directly upstream of every mem_addr_gen_* stage: drives the h_cnt/v_cnt they decode into pixel_addr, plus hsync/vsync/valid to the VGA pins and the RGB mux.
- Also produces per-frame and per-scroll-step pulses, so scrolling image stages step once per N frames instead of once per fast clock.

---
 rtl/vga_timing_gen.sv | 81 ++++++++
 tb/tb_vga_timing_gen.sv | 116 +++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing (h/v counters, syncs, valid) plus frame and scroll-step pulses.
// Define VGA_TIMING_SYNC_DELAY_EN to delay hsync/vsync/valid by one pixel to match a 1-cycle block ROM.
module vga_timing_gen #(
    parameter int CLK_DIV         = 4,
    parameter int H_VIS           = 640,
    parameter int H_FP            = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int V_VIS           = 480,
    parameter int V_FP            = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int FRAMES_PER_STEP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scroll_hold,
    output logic       pix_stb,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       hsync,
    output logic       vsync,
    output logic       valid,
    output logic       frame_tick,
    output logic       scroll_tick
);
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    logic [4:0] div;
    logic [7:0] frame_cnt;
    logic       h_last, v_last, h_act, v_act, vis;
    always_comb begin
        h_last = h_cnt == 10'(H_TOTAL - 1);
        v_last = v_cnt == 10'(V_TOTAL - 1);
        h_act  = (h_cnt >= 10'(H_VIS + H_FP)) && (h_cnt < 10'(H_VIS + H_FP + H_SYNC));
        v_act  = (v_cnt >= 10'(V_VIS + V_FP)) && (v_cnt < 10'(V_VIS + V_FP + V_SYNC));
        vis    = (h_cnt < 10'(H_VIS)) && (v_cnt < 10'(V_VIS));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            div        <= '0;
            pix_stb    <= 1'b0;
            h_cnt      <= '0;
            v_cnt      <= '0;
            frame_tick <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            div        <= (div == 5'(CLK_DIV - 1)) ? '0 : div + 5'd1;
            pix_stb    <= div == 5'(CLK_DIV - 1);
            frame_tick <= pix_stb && h_last && v_last;
            if (pix_stb) begin
                h_cnt <= h_last ? '0 : h_cnt + 10'd1;
                if (h_last)
                    v_cnt <= v_last ? '0 : v_cnt + 10'd1;
            end
            if (frame_tick && !scroll_hold)
                frame_cnt <= (frame_cnt == 8'(FRAMES_PER_STEP - 1)) ? '0 : frame_cnt + 8'd1;
        end
    end
    // hold is sampled on the frame_tick clock itself, so the step pulse coincides with it
    assign scroll_tick = frame_tick && !scroll_hold && (frame_cnt == 8'(FRAMES_PER_STEP - 1));
`ifdef VGA_TIMING_SYNC_DELAY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            valid <= 1'b0;
        end else if (pix_stb) begin
            hsync <= !h_act;
            vsync <= !v_act;
            valid <= vis;
        end
    end
`else
    always_comb begin
        hsync = rst || !h_act;
        vsync = rst || !v_act;
        valid = !rst && vis;
    end
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of vga_timing_gen on a shrunken raster (15x10 pixels, 4 clks/pixel).
module tb_vga_timing_gen;
    localparam int CD = 4, HV = 8, HF = 2, HS = 3, HB = 2, VV = 6, VF = 1, VS = 2, VB = 1, FPS = 4;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FR = HT * VT * CD;
    logic clk = 1'b0, rst = 1'b1, scroll_hold = 1'b0;
    logic pix_stb, hsync, vsync, valid, frame_tick, scroll_tick;
    logic [9:0] h_cnt, v_cnt;
    int errors = 0, checks = 0;
    bit found;

    vga_timing_gen #(.CLK_DIV(CD), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .FRAMES_PER_STEP(FPS)) dut (
        .clk(clk), .rst(rst), .scroll_hold(scroll_hold), .pix_stb(pix_stb),
        .h_cnt(h_cnt), .v_cnt(v_cnt), .hsync(hsync), .vsync(vsync), .valid(valid),
        .frame_tick(frame_tick), .scroll_tick(scroll_tick));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset();
        chk("rst_pix_stb", 32'(pix_stb), 0);
        chk("rst_h_cnt", 32'(h_cnt), 0);
        chk("rst_v_cnt", 32'(v_cnt), 0);
        chk("rst_hsync", 32'(hsync), 1);
        chk("rst_vsync", 32'(vsync), 1);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_frame_tick", 32'(frame_tick), 0);
        chk("rst_scroll_tick", 32'(scroll_tick), 0);
    endtask

    // e = clock edges since reset release; t1/t2 = frame numbers expected to carry scroll_tick
    task automatic check_model(input int e, input int t1, input int t2);
        int s, h, v, m, ph, pv;
        bit ft, hs, vs, vl;
        s  = (e - 1) / CD;
        h  = s % HT;
        v  = (s / HT) % VT;
        m  = (e - 1) / FR;
        ft = (e > 1) && ((e - 1) % FR == 0);
`ifdef VGA_TIMING_SYNC_DELAY_EN
        ph = (s + HT * VT - 1) % HT;
        pv = ((s + HT * VT - 1) / HT) % VT;
        if (s == 0) begin
            hs = 1; vs = 1; vl = 0;
        end else begin
            hs = !(ph >= HV + HF && ph < HV + HF + HS);
            vs = !(pv >= VV + VF && pv < VV + VF + VS);
            vl = ph < HV && pv < VV;
        end
`else
        ph = h;
        pv = v;
        hs = !(ph >= HV + HF && ph < HV + HF + HS);
        vs = !(pv >= VV + VF && pv < VV + VF + VS);
        vl = ph < HV && pv < VV;
`endif
        chk("pix_stb", 32'(pix_stb), 32'(e % CD == 0));
        chk("h_cnt", 32'(h_cnt), 32'(h));
        chk("v_cnt", 32'(v_cnt), 32'(v));
        chk("hsync", 32'(hsync), 32'(hs));
        chk("vsync", 32'(vsync), 32'(vs));
        chk("valid", 32'(valid), 32'(vl));
        chk("frame_tick", 32'(frame_tick), 32'(ft));
        chk("scroll_tick", 32'(scroll_tick), 32'(ft && (m == t1 || m == t2)));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset();
        rst = 1'b0;
        #1;
        chk("release_h_cnt", 32'(h_cnt), 0);
`ifdef VGA_TIMING_SYNC_DELAY_EN
        chk("release_valid", 32'(valid), 0);
`else
        chk("release_valid", 32'(valid), 1);
`endif
        for (int e = 1; e <= 40; e++) begin
            @(negedge clk);
            chk("early_pix_stb", 32'(pix_stb), 32'(e % CD == 0));
            chk("early_h_cnt", 32'(h_cnt), 32'((e - 1) / CD));
        end
        for (int e = 41; e <= 9 * FR + 10; e++) begin
            @(negedge clk);
            check_model(e, 4, 8);
        end
        found = 0;
        for (int i = 0; i < 2 * FR && !found; i++) begin
            @(negedge clk);
            found = (h_cnt == 10'd11) && (v_cnt == 10'd4);
        end
        chk("midframe_reached", 32'(found), 1);
        chk("midframe_hsync", 32'(hsync), 0);
        rst = 1'b1;
        @(negedge clk);
        check_reset();
        rst = 1'b0;
        for (int e = 1; e <= 9 * FR + 10; e++) begin
            @(negedge clk);
            check_model(e, 5, 9);
            scroll_hold = (e >= 2 * FR + FR / 2) && (e < 3 * FR + FR / 2);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
